tohost_exit_monitor: RTL and testbench



---
 rtl/tohost_pkg.sv | 25 ++
 rtl/sat_counter.sv | 23 ++
 rtl/tohost_exit_monitor.sv | 113 +++++++++++
 tb/tb_tohost_exit_monitor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tohost_pkg.sv
// Shared types and constants for the tohost exit monitor.
// State encoding, exit-bit position and the reserved hang code.
package tohost_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PASS,
    FAIL
  } state_t;

  localparam int EXIT_BIT   = 0;
  localparam int MAX_CODE_W = 128;

  // All-ones pattern of the given width; callers slice to their code width.
  function automatic logic [MAX_CODE_W-1:0] hang_code(input int code_w);
    logic [MAX_CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CODE_W; i++) begin
      if (i < code_w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tohost_exit_monitor.sv
// Harness-side tohost monitor: decodes exit writes, drains,
// then holds a sticky pass/fail level; optional hang watchdog.
module tohost_exit_monitor
  import tohost_pkg::*;
#(
  parameter int DATA_W       = 64,
  parameter int DRAIN_CYCLES = 16,
  parameter int HANG_CYCLES  = 0,
  parameter int CNT_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tohost_valid,
  output logic              tohost_ready,
  input  logic [DATA_W-1:0] tohost_bits,
  output logic              io_success,
  output logic              io_failure,
  output logic [DATA_W-2:0] io_fail_code,
  output logic [CNT_W-1:0]  io_write_count
);

  localparam int CODE_W = DATA_W - 1;
  localparam logic [MAX_CODE_W-1:0] HANG_FULL = hang_code(CODE_W);
  localparam logic [CODE_W-1:0] HANG_CODE = HANG_FULL[CODE_W-1:0];
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD =
    DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HANG_LAST =
    CNT_W'((HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0);

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic [CODE_W-1:0]   bits_code;
  logic [CNT_W-1:0]    hang_cnt;
  logic                in_run;
  logic                accept;
  logic                exit_wr;
  logic                hang_inc;
  logic                hang_hit;

  assign in_run       = (state_q == RUN);
  assign tohost_ready = in_run && !reset;
  assign accept       = tohost_valid && tohost_ready;
  assign exit_wr      = tohost_bits[EXIT_BIT];
  assign bits_code    = tohost_bits[DATA_W-1:EXIT_BIT+1];
  assign hang_inc     = (HANG_CYCLES > 0) && in_run && !accept;
  assign hang_hit     = hang_inc && (hang_cnt == HANG_LAST);

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clock (clock),
    .reset (reset),
    .clear (1'b0),
    .inc   (accept && !exit_wr),
    .count (io_write_count)
  );

  sat_counter #(.W(CNT_W)) u_hang_cnt (
    .clock (clock),
    .reset (reset),
    .clear (accept),
    .inc   (hang_inc),
    .count (hang_cnt)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    drn_d   = drn_q;
    unique case (state_q)
      RUN: begin
        if (accept && exit_wr) begin
          code_d = bits_code;
          if (DRAIN_CYCLES > 0) begin
            drn_d   = DRN_LOAD;
            state_d = DRAIN;
          end else begin
            state_d = (bits_code == '0) ? PASS : FAIL;
          end
        end else if (hang_hit) begin
          code_d  = HANG_CODE;
          state_d = FAIL;
        end
      end
      DRAIN: begin
        if (drn_q == '0) begin
          state_d = (code_q == '0) ? PASS : FAIL;
        end else begin
          drn_d = drn_q - DRN_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      code_q  <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      drn_q   <= drn_d;
    end
  end

  assign io_success   = (state_q == PASS);
  assign io_failure   = (state_q == FAIL);
  assign io_fail_code = (state_q == FAIL) ? code_q : '0;

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Directed bench: instance A (drain 16, no watchdog, 64-bit),
// instance B (no drain, hang 10, 8-bit data, 4-bit counters).
module tb_tohost_exit_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        a_valid = 1'b0;
  logic [63:0] a_bits = '0;
  logic        a_ready, a_succ, a_fail;
  logic [62:0] a_code;
  logic [31:0] a_wc;

  logic        b_valid = 1'b0;
  logic [7:0]  b_bits = '0;
  logic        b_ready, b_succ, b_fail;
  logic [6:0]  b_code;
  logic [3:0]  b_wc;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tohost_exit_monitor #(
    .DATA_W(64), .DRAIN_CYCLES(16), .HANG_CYCLES(0), .CNT_W(32)
  ) u_a (
    .clock          (clk),
    .reset          (reset),
    .tohost_valid   (a_valid),
    .tohost_ready   (a_ready),
    .tohost_bits    (a_bits),
    .io_success     (a_succ),
    .io_failure     (a_fail),
    .io_fail_code   (a_code),
    .io_write_count (a_wc)
  );

  tohost_exit_monitor #(
    .DATA_W(8), .DRAIN_CYCLES(0), .HANG_CYCLES(10), .CNT_W(4)
  ) u_b (
    .clock          (clk),
    .reset          (reset),
    .tohost_valid   (b_valid),
    .tohost_ready   (b_ready),
    .tohost_bits    (b_bits),
    .io_success     (b_succ),
    .io_failure     (b_fail),
    .io_fail_code   (b_code),
    .io_write_count (b_wc)
  );

  typedef struct {
    logic        valid;
    logic [63:0] bits;
    logic        ready;
    logic [31:0] wc;
    logic        succ;
    logic        fail;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic seen;

    // 1: reset held with valid high
    a_valid = 1'b1; a_bits = 64'h2;
    b_valid = 1'b1; b_bits = 8'h2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_ready_a", a_ready, 0);
      chk("rst_ready_b", b_ready, 0);
    end
    chk("rst_succ_a", a_succ, 0);
    chk("rst_fail_a", a_fail, 0);
    chk("rst_code_a", a_code, 0);
    chk("rst_wc_a", a_wc, 0);
    chk("rst_succ_b", b_succ, 0);
    chk("rst_fail_b", b_fail, 0);
    chk("rst_code_b", b_code, 0);
    chk("rst_wc_b", b_wc, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rel_ready_a", a_ready, 1);
    chk("rel_ready_b", b_ready, 1);

    // 2: three console writes, exit 0 with 16-cycle drain
    vq.push_back('{1'b1, 64'h10, 1'b1, 32'd1, 1'b0, 1'b0});
    vq.push_back('{1'b1, 64'h20, 1'b1, 32'd2, 1'b0, 1'b0});
    vq.push_back('{1'b1, 64'h30, 1'b1, 32'd3, 1'b0, 1'b0});
    vq.push_back('{1'b1, 64'h1,  1'b1, 32'd3, 1'b0, 1'b0});
    for (int i = 1; i <= 16; i++)
      vq.push_back('{1'b0, 64'h0, 1'b0, 32'd3, (i == 16), 1'b0});
    for (int i = 0; i < 2; i++)
      vq.push_back('{1'b1, 64'h10, 1'b0, 32'd3, 1'b1, 1'b0});
    foreach (vq[i]) begin
      a_valid = vq[i].valid;
      a_bits  = vq[i].bits;
      #1;
      chk("vec_ready", a_ready, vq[i].ready);
      tick();
      chk("vec_wc", a_wc, vq[i].wc);
      chk("vec_succ", a_succ, vq[i].succ);
      chk("vec_fail", a_fail, vq[i].fail);
      chk("vec_code", a_code, 0);
    end
    a_valid = 1'b0;

    // 5: reset during drain with 5 cycles left
    pulse_reset();
    a_valid = 1'b1; a_bits = 64'h10;
    tick();
    a_bits = 64'h1;
    tick();
    a_valid = 1'b0;
    repeat (11) tick();
    chk("drn_pre_succ", a_succ, 0);
    reset = 1'b1;
    tick();
    chk("drn_rst_succ", a_succ, 0);
    chk("drn_rst_fail", a_fail, 0);
    chk("drn_rst_wc", a_wc, 0);
    chk("drn_rst_ready", a_ready, 0);
    reset = 1'b0;
    #1;
    chk("drn_rel_ready", a_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | a_succ | a_fail;
    end
    chk("drn_no_late_flag", seen, 0);

    // 3: exit code 3 with no drain
    pulse_reset();
    b_valid = 1'b1; b_bits = 8'h07;
    tick();
    chk("fc_fail", b_fail, 1);
    chk("fc_succ", b_succ, 0);
    chk("fc_code", b_code, 3);
    chk("fc_ready", b_ready, 0);
    b_bits = 8'h10;
    repeat (3) tick();
    chk("fc_ign_wc", b_wc, 0);
    chk("fc_hold_fail", b_fail, 1);
    chk("fc_hold_code", b_code, 3);
    b_valid = 1'b0;

    // 4: hang watchdog
    pulse_reset();
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("hang_fail", b_fail, (i == 10));
    end
    chk("hang_code", b_code, 7'h7f);
    pulse_reset();
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("hang2_nofail", b_fail, 0);
    end
    b_valid = 1'b1; b_bits = 8'h00;
    tick();
    b_valid = 1'b0;
    chk("hang2_save_fail", b_fail, 0);
    chk("hang2_save_wc", b_wc, 1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("hang2_restart", b_fail, (i == 10));
    end

    // 6: write counter saturation
    pulse_reset();
    b_valid = 1'b1; b_bits = 8'h02;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("sat_wc", b_wc, (i > 15) ? 15 : i);
    end
    b_valid = 1'b0;
    chk("sat_fail", b_fail, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
